pcihellocore_pio_out_ext: RTL and testbench



---
 rtl/pcihellocore_pio_out_pkg.sv | 14 +
 rtl/pcihellocore_blink_timer.sv | 48 ++++
 rtl/pcihellocore_pio_out_ext.sv | 125 ++++++++++++
 tb/tb_pcihellocore_pio_out_ext.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_pio_out_pkg.sv
// Shared register-map constants for the pcihellocore extended output PIO.
package pcihellocore_pio_out_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_SET          = 3'd1;
    localparam logic [2:0] ADDR_CLEAR        = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd4;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS       = 3'd6;

    localparam int unsigned STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/pcihellocore_blink_timer.sv
// Blink prescaler: counts to period, then flips phase and pulses wrap.
// A reload (period rewrite) clears counter and phase and suppresses that cycle's wrap.
module pcihellocore_blink_timer #(
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    reload,
    output logic                    phase,
    output logic                    wrap
);

    logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
    logic                    phase_q, phase_d;

    always_comb begin
        counter_d = counter_q;
        phase_d   = phase_q;
        wrap      = 1'b0;
        if (reload || (period == '0)) begin
            counter_d = '0;
            phase_d   = 1'b0;
        end else if (counter_q == period) begin
            counter_d = '0;
            phase_d   = ~phase_q;
            wrap      = 1'b1;
        end else if (counter_q > period) begin
            // Defensive: never run the long way round past a shrunken period.
            counter_d = '0;
        end else begin
            counter_d = counter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            phase_q   <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pcihellocore_pio_out_ext.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-bit hardware blink.
// Define PIO_OUT_IRQ_EN to add the wrap status flag and the irq port.
module pcihellocore_pio_out_ext
    import pcihellocore_pio_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] RESET_VALUE  = 32'd170,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
`ifdef PIO_OUT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam logic [DATA_WIDTH-1:0] RESET_DATA = RESET_VALUE[DATA_WIDTH-1:0];

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic [PERIOD_WIDTH-1:0] wd_period;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    period_wr;
    logic                    phase;
    logic                    wrap;

    assign wr_en     = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign wd_period = writedata[PERIOD_WIDTH-1:0];
    assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:         data_d   = wd_data;
                ADDR_SET:          data_d   = data_q | wd_data;
                ADDR_CLEAR:        data_d   = data_q & ~wd_data;
                ADDR_TOGGLE:       data_d   = data_q ^ wd_data;
                ADDR_BLINK_MASK:   mask_d   = wd_data;
                ADDR_BLINK_PERIOD: period_d = wd_period;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_DATA;
            mask_q   <= '0;
            period_q <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    // Timer sees the old period; the rewrite itself is signalled as a reload.
    pcihellocore_blink_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .reload  (period_wr),
        .phase   (phase),
        .wrap    (wrap)
    );

    assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase}});

`ifdef PIO_OUT_IRQ_EN
    logic flag_q, flag_d;

    // A wrap in the same cycle as the W1C wins.
    always_comb begin
        flag_d = flag_q;
        if (wrap) begin
            flag_d = 1'b1;
        end else if (wr_en && (address == ADDR_STATUS) && writedata[STATUS_WRAP_BIT]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign irq = flag_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:         readdata[DATA_WIDTH-1:0]   = data_q;
            ADDR_SET:          readdata[DATA_WIDTH-1:0]   = out_port;
            ADDR_BLINK_MASK:   readdata[DATA_WIDTH-1:0]   = mask_q;
            ADDR_BLINK_PERIOD: readdata[PERIOD_WIDTH-1:0] = period_q;
`ifdef PIO_OUT_IRQ_EN
            ADDR_STATUS:       readdata[STATUS_WRAP_BIT]  = flag_q;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcihellocore_pio_out_ext.sv
// Directed, table-driven bench for pcihellocore_pio_out_ext (default parameters).
module tb_pcihellocore_pio_out_ext;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
`ifdef PIO_OUT_IRQ_EN
    logic        irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pcihellocore_pio_out_ext dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef PIO_OUT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        cs;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns 1 time unit after the write edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Reset asserted mid-cycle while blinking.
        wr(3'd0, 32'h33);
        wr(3'd4, 32'h0F);
        wr(3'd5, 32'd1);
        repeat (3) step();
        #3 reset_n = 1'b0;
        #1 check("reset_out_port", out_port, 32'hAA);
        rd_check("reset_rd_data", 3'd0, 32'hAA);
        rd_check("reset_rd_mask", 3'd4, 32'h0);
        rd_check("reset_rd_period", 3'd5, 32'h0);
        step();
        reset_n = 1'b1;
        step();

        // wr, cs, waddr, wdata, raddr, exp_rd, exp_out
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd0, 32'hAA,       32'hAA});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd7, 32'h0,        32'hAA});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0F,       3'd0, 32'h0F,       32'h0F});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 32'hF0,       3'd0, 32'hFF,       32'hFF});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd1, 32'hFF,       32'hFF});
        vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h03,       3'd0, 32'hFC,       32'hFC});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd2, 32'h0,        32'hFC});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 32'h81,       3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd3, 32'h0,        32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h12345678, 3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'hFFFFFFFF, 3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'hFFFFFFFF, 3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 32'hFFFFFFFF, 3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'hFF,       3'd4, 32'h0,        32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h3,        3'd5, 32'h0,        32'h7D});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 32'h1,        3'd6, 32'h0,        32'h7D});
        vecs.push_back('{1'b1, 1'b1, 3'd7, 32'hFFFF,     3'd7, 32'h0,        32'h7D});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        3'd0, 32'h7D,       32'h7D});
        vecs.push_back('{1'b1, 1'b1, 3'd4, 32'h55,       3'd4, 32'h55,       32'h7D});
        vecs.push_back('{1'b1, 1'b1, 3'd4, 32'h0,        3'd4, 32'h0,        32'h7D});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 32'hFFFFFFFF, 3'd5, 32'h00FFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 32'h0,        3'd5, 32'h0,        32'hFFFFFFFF});

        foreach (vecs[i]) begin
            if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].cs);
            rd_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
        end

        // Blink: half-period of period+1 = 4 cycles on bit 0 only.
        wr(3'd0, 32'h0);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'd3);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("blink_k%0d", k), out_port, ((k / 4) % 2 == 1) ? 32'h1 : 32'h0);
        end
`ifndef PIO_OUT_IRQ_EN
        rd_check("status_no_feature", 3'd6, 32'h0);
`endif
        wr(3'd5, 32'd0);
        check("blink_off_now", out_port, 32'h0);
        repeat (5) step();
        check("blink_off_hold", out_port, 32'h0);

        // Period rewrite on the cycle the counter equals the old period.
        wr(3'd5, 32'd3);
        repeat (3) step();
        wr(3'd5, 32'd5);
        check("reload_no_toggle", out_port, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("reload_k%0d", k), out_port, (k == 6) ? 32'h1 : 32'h0);
        end
        wr(3'd4, 32'h0);
        check("mask_clear_immediate", out_port, 32'h0);
        wr(3'd5, 32'd0);

`ifdef PIO_OUT_IRQ_EN
        wr(3'd6, 32'h1);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        wr(3'd5, 32'd1);
        check("irq_e0", {31'b0, irq}, 32'h0);
        step();
        check("irq_e1", {31'b0, irq}, 32'h0);
        step();
        check("irq_e2", {31'b0, irq}, 32'h1);
        rd_check("status_set", 3'd6, 32'h1);
        wr(3'd6, 32'h1);
        check("irq_w1c", {31'b0, irq}, 32'h0);
        wr(3'd6, 32'h1);
        check("irq_w1c_vs_wrap", {31'b0, irq}, 32'h1);
        rd_check("status_kept", 3'd6, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
